// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: ALUOp/funct decode, single-cycle logic/arith ops,
// iterative shifter and shift-add multiplier behind valid/ready handshakes.
module alu_exec_unit #(
    parameter int XLEN            = 32,
    parameter int SHIFT_PER_CYCLE = 1,
    parameter bit MUL_EN          = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      alu_op,
    input  logic            op5,
    input  logic [2:0]      funct3,
    input  logic            funct7_5,
    input  logic [XLEN-1:0] src_a,
    input  logic [XLEN-1:0] src_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic [3:0]      alu_ctrl
);

    localparam int SW = $clog2(XLEN);
    localparam int CW = SW + 1;
    localparam logic [CW-1:0] SPC   = CW'(SHIFT_PER_CYCLE);
    localparam logic [CW-1:0] MUL_N = CW'(XLEN);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [3:0] C_ADD  = 4'd0;
    localparam logic [3:0] C_SUB  = 4'd1;
    localparam logic [3:0] C_AND  = 4'd2;
    localparam logic [3:0] C_OR   = 4'd3;
    localparam logic [3:0] C_XOR  = 4'd4;
    localparam logic [3:0] C_SLT  = 4'd5;
    localparam logic [3:0] C_SLTU = 4'd6;
    localparam logic [3:0] C_SLL  = 4'd7;
    localparam logic [3:0] C_SRL  = 4'd8;
    localparam logic [3:0] C_SRA  = 4'd9;
    localparam logic [3:0] C_MUL  = 4'd10;

    logic [1:0]      state_q, state_d;
    logic [3:0]      ctrl_q, ctrl_d;
    logic [XLEN-1:0] result_q, result_d;
    logic            zero_q, zero_d;
    logic [XLEN-1:0] a_q, a_d;
    logic [XLEN-1:0] b_q, b_d;
    logic [XLEN-1:0] acc_q, acc_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    logic [3:0]      dec_ctrl;
    logic [XLEN-1:0] alu_res;
    logic [SW-1:0]   shamt;
    logic            dec_shift;
    logic            dec_mul;
    logic            accept;
    logic [CW-1:0]   step;
    logic [XLEN-1:0] sh_res;
    logic [XLEN-1:0] mul_acc;

    assign in_ready  = !flush && (state_q == S_IDLE ||
                                  (state_q == S_DONE && out_ready));
    assign accept    = in_valid && in_ready;
    assign out_valid = (state_q == S_DONE);
    assign result    = result_q;
    assign zero      = zero_q;
    assign alu_ctrl  = ctrl_q;
    assign shamt     = src_b[SW-1:0];

    always_comb begin
        dec_ctrl = C_ADD;
        case (alu_op)
            2'b00: dec_ctrl = C_ADD;
            2'b01: dec_ctrl = C_SUB;
            2'b11: dec_ctrl = MUL_EN ? C_MUL : C_ADD;
            default: begin
                case (funct3)
                    3'b000: dec_ctrl = (op5 && funct7_5) ? C_SUB : C_ADD;
                    3'b001: dec_ctrl = C_SLL;
                    3'b010: dec_ctrl = C_SLT;
                    3'b011: dec_ctrl = C_SLTU;
                    3'b100: dec_ctrl = C_XOR;
                    3'b101: dec_ctrl = funct7_5 ? C_SRA : C_SRL;
                    3'b110: dec_ctrl = C_OR;
                    default: dec_ctrl = C_AND;
                endcase
            end
        endcase
    end

    assign dec_shift = (dec_ctrl == C_SLL) || (dec_ctrl == C_SRL) ||
                       (dec_ctrl == C_SRA);
    assign dec_mul   = (dec_ctrl == C_MUL);

    // Shifts reach here only with shamt 0, so they pass A through.
    always_comb begin
        alu_res = src_a;
        case (dec_ctrl)
            C_ADD:  alu_res = src_a + src_b;
            C_SUB:  alu_res = src_a - src_b;
            C_AND:  alu_res = src_a & src_b;
            C_OR:   alu_res = src_a | src_b;
            C_XOR:  alu_res = src_a ^ src_b;
            C_SLT:  alu_res = {{(XLEN-1){1'b0}},
                               $signed(src_a) < $signed(src_b)};
            C_SLTU: alu_res = {{(XLEN-1){1'b0}}, src_a < src_b};
            default: alu_res = src_a;
        endcase
    end

    always_comb begin
        step   = (cnt_q < SPC) ? cnt_q : SPC;
        sh_res = a_q;
        case (ctrl_q)
            C_SLL: sh_res = a_q << step;
            C_SRL: sh_res = a_q >> step;
            C_SRA: sh_res = $signed(a_q) >>> step;
            default: sh_res = a_q;
        endcase
    end

    assign mul_acc = acc_q + (b_q[0] ? a_q : '0);

    always_comb begin
        state_d  = state_q;
        ctrl_d   = ctrl_q;
        result_d = result_q;
        zero_d   = zero_q;
        a_d      = a_q;
        b_d      = b_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;

        case (state_q)
            S_BUSY: begin
                if (ctrl_q == C_MUL) begin
                    acc_d = mul_acc;
                    a_d   = a_q << 1;
                    b_d   = b_q >> 1;
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == CW'(1)) begin
                        state_d  = S_DONE;
                        result_d = mul_acc;
                        zero_d   = (mul_acc == '0);
                    end
                end else begin
                    a_d   = sh_res;
                    cnt_d = cnt_q - step;
                    if (cnt_q == step) begin
                        state_d  = S_DONE;
                        result_d = sh_res;
                        zero_d   = (sh_res == '0);
                    end
                end
            end
            S_DONE: begin
                if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (accept) begin
            ctrl_d = dec_ctrl;
            if (dec_mul) begin
                a_d     = src_a;
                b_d     = src_b;
                acc_d   = '0;
                cnt_d   = MUL_N;
                state_d = S_BUSY;
            end else if (dec_shift && shamt != '0) begin
                a_d     = src_a;
                cnt_d   = {1'b0, shamt};
                state_d = S_BUSY;
            end else begin
                result_d = alu_res;
                zero_d   = (alu_res == '0);
                state_d  = S_DONE;
            end
        end

        // Squash drops any in-flight work; in_ready already blocks accept.
        if (flush) begin
            state_d = S_IDLE;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            ctrl_q   <= C_ADD;
            result_q <= '0;
            zero_q   <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            ctrl_q   <= ctrl_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            a_q      <= a_d;
            b_q      <= b_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule
